vote_input_conditioner: RTL
===========================

Name: vote_input_conditioner

Overview:
- Front-end stage that drives the voting machine's `in_candidate_1..3` inputs from raw, bouncy, asynchronous push-buttons.
- For each button it synchronises, debounces and edge-detects the input.
- It enforces a one-vote-per-press rule with a post-vote lockout, emitting at most one single-cycle vote pulse per accepted press.
- It rejects simultaneous multi-button presses.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must differ from the debounced level before the debounced level updates (≥2).
- LOCKOUT_CYCLES, 8, minimum cycles spent in LOCKOUT after any accepted or rejected press (≥1).
- CNT_W, 8, width of the debounce and lockout counters; must hold max(DEBOUNCE_CYCLES, LOCKOUT_CYCLES).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- mode  in  2  same encoding as the voting machine; 1 = voting, anything else = conditioner idle
- btn_1  in  1  raw button, candidate 1 (asynchronous, may bounce)
- btn_2  in  1  raw button, candidate 2
- btn_3  in  1  raw button, candidate 3
- vote_1  out  1  single-cycle vote pulse to in_candidate_1
- vote_2  out  1  single-cycle vote pulse to in_candidate_2
- vote_3  out  1  single-cycle vote pulse to in_candidate_3
- busy  out  1  high whenever state ≠ READY
- invalid  out  1  single-cycle pulse on a rejected multi-button press

Behaviour:
- Reset (reset=0, asynchronous):
  - sync flops, debounced levels, counters and all outputs = 0; state = IDLE; busy = 1.
  - Reset mid-pulse or mid-lockout kills everything immediately, with no pending vote afterwards.
- Synchroniser: 2-flop chain per button, giving s_x.
- Debounce, per button:
  - If s_x ≠ db_x: cnt_x increments.
  - When cnt_x == DEBOUNCE_CYCLES-1 and s_x ≠ db_x: db_x <= s_x and cnt_x <= 0.
  - If s_x == db_x: cnt_x <= 0, so any glitch restarts the count.
  - Debounce runs in every state, including IDLE.
- rise_x = db_x transitioning 0→1, registered as a one-cycle event.
- FSM states: IDLE, READY, PULSE, LOCKOUT.
  - IDLE:
    - Outputs 0.
    - → READY when mode==1 and all db_x==0, so a button held while entering voting mode is not counted.
  - READY:
    - Exactly one rise_x → PULSE, latching which candidate.
    - Two or three rise_x in the same cycle → LOCKOUT with invalid=1 for one cycle; no vote.
    - No rise → stay.
  - PULSE:
    - The latched vote_x = 1 for exactly one cycle.
    - → LOCKOUT with the lockout counter cleared.
  - LOCKOUT:
    - The counter increments each cycle and saturates at LOCKOUT_CYCLES.
    - → READY when counter == LOCKOUT_CYCLES and all db_x == 0.
    - Rises during LOCKOUT are discarded, never queued.
  - From any state, mode ≠ 1 → IDLE on the next edge; a PULSE that has not yet been issued is suppressed.
- Latency: raw btn high sampled at edge 0, held stable, in READY → vote_x high from edge DEBOUNCE_CYCLES+2 to DEBOUNCE_CYCLES+3. With defaults this is edges 6 to 7.
- vote_1..3 are mutually exclusive and never high for more than one cycle. invalid and vote_x are never high together.
- busy = (state ≠ READY), registered with the state.
- Counter width: no wrap is permitted; counters saturate.

Test Plan:
- Reset then mode=1, btn_1 raised cleanly at edge 10 and held 20 cycles → vote_1 high for exactly one cycle at edge 16; count_candidate_1 increments by 1; busy returns low when btn_1 is released and ≥8 cycles have passed since the pulse.
- btn_2 bounces 1,0,1,0 every cycle for 6 cycles, then stays 1 → a single vote_2 pulse, 6 edges after the last bounce settles; no extra pulses.
- btn_1 and btn_3 raised on the same edge → invalid pulses once; vote_1 = vote_3 = 0; conditioner returns to READY only after both are released and 8 cycles have passed.
- btn_3 held continuously for 50 cycles → exactly one vote_3; re-press after release and lockout → second vote_3. Total over 10 such presses = 10.
- btn_1 pressed during LOCKOUT and released before lockout ends → no vote; next clean press is counted normally.
- mode switched to 2 at the edge where rise_1 occurs → no vote_1; busy=1. reset asserted mid-LOCKOUT → all outputs 0 immediately; with mode=1 and buttons released, state reaches READY 1 edge after reset deasserts.

Source files
------------

// File: rtl/vote_input_conditioner.sv
// Push-button front end for the voting machine: synchronise, debounce and edge-detect
// three buttons, then issue at most one vote pulse per accepted press with a lockout.
module vote_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       btn_1,
  input  logic       btn_2,
  input  logic       btn_3,
  output logic       vote_1,
  output logic       vote_2,
  output logic       vote_3,
  output logic       busy,
  output logic       invalid
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    PULSE   = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  logic [2:0]       btn;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       db;
  logic [2:0]       rise;
  logic             single;
  logic             multi;
  state_t           state;
  logic [2:0]       vote;
  logic [CNT_W-1:0] lock_cnt;

  assign btn = {btn_3, btn_2, btn_1};

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 3'b000;
      sync2 <= 3'b000;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             db_q;
    logic             rise_q;

    // Debounce: the level must disagree for DEBOUNCE_CYCLES straight cycles; rise fires with the update
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
      end else if (sync2[i] != db_q) begin
        if (cnt == DEB_LAST) begin
          cnt    <= '0;
          db_q   <= sync2[i];
          rise_q <= sync2[i];
        end else begin
          cnt    <= cnt + CNT_W'(1);
          rise_q <= 1'b0;
        end
      end else begin
        cnt    <= '0;
        rise_q <= 1'b0;
      end
    end

    assign db[i]   = db_q;
    assign rise[i] = rise_q;
  end

  // Classify the rise vector as one clean press or a simultaneous multi-press
  always_comb begin
    single = (rise == 3'b001) || (rise == 3'b010) || (rise == 3'b100);
    multi  = (rise != 3'b000) && !single;
  end

  // Control FSM with registered vote/invalid/busy outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      vote     <= 3'b000;
      invalid  <= 1'b0;
      busy     <= 1'b1;
      lock_cnt <= '0;
    end else if (mode != 2'd1) begin
      state    <= IDLE;
      vote     <= 3'b000;
      invalid  <= 1'b0;
      busy     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          vote     <= 3'b000;
          invalid  <= 1'b0;
          lock_cnt <= '0;
          // A button already held when voting starts must be released first
          if (db == 3'b000) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b1;
          end
        end
        READY: begin
          lock_cnt <= '0;
          if (single) begin
            state   <= PULSE;
            vote    <= rise;
            invalid <= 1'b0;
            busy    <= 1'b1;
          end else if (multi) begin
            state   <= LOCKOUT;
            vote    <= 3'b000;
            invalid <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state   <= READY;
            vote    <= 3'b000;
            invalid <= 1'b0;
            busy    <= 1'b0;
          end
        end
        PULSE: begin
          state    <= LOCKOUT;
          vote     <= 3'b000;
          invalid  <= 1'b0;
          busy     <= 1'b1;
          lock_cnt <= '0;
        end
        LOCKOUT: begin
          vote    <= 3'b000;
          invalid <= 1'b0;
          if ((lock_cnt == LOCK_MAX) && (db == 3'b000)) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            state <= LOCKOUT;
            busy  <= 1'b1;
          end
          if (lock_cnt != LOCK_MAX) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end else begin
            lock_cnt <= lock_cnt;
          end
        end
        default: begin
          state    <= IDLE;
          vote     <= 3'b000;
          invalid  <= 1'b0;
          busy     <= 1'b1;
          lock_cnt <= '0;
        end
      endcase
    end
  end

  assign vote_1 = vote[0];
  assign vote_2 = vote[1];
  assign vote_3 = vote[2];

endmodule
